// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter with address decode and access checking.
// Master 0 (CPU M stage) normally wins; master 1 is forced a grant after
// LOSE_MAX consecutive losses. Each transaction takes three cycles
// (IDLE -> ACC -> RSP). Reads are returned with a one-cycle ack.
module bus_arbiter #(
  parameter logic [31:0] DM_END   = 32'h0000_2FFF,
  parameter logic [1:0]  LOSE_MAX = 2'd3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_byteen,
  output logic        dm_sel,
  output logic        t1_sel,
  output logic        t2_sel,
  input  logic [31:0] dm_rdata,
  input  logic [31:0] t1_rdata,
  input  logic [31:0] t2_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_t;

  // Timer register windows (three words each; the third word is read-only).
  localparam logic [31:0] T1_LO = 32'h0000_7F00;
  localparam logic [31:0] T1_HI = 32'h0000_7F0B;
  localparam logic [31:0] T2_LO = 32'h0000_7F10;
  localparam logic [31:0] T2_HI = 32'h0000_7F1B;

  state_t      state_q, state_d;
  logic [1:0]  lose_cnt_q, lose_cnt_d;
  logic        win_q, win_d;          // 0 = master 0, 1 = master 1
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  byteen_q, byteen_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        any_req;
  logic        grant_m1;
  logic        hit_dm, hit_t1, hit_t2, hit_timer;
  logic        is_write;
  logic        acc_err;
  logic [31:0] dev_rdata_mux;

  // Arbitration decision: master 1 wins when master 0 is silent or when it
  // has been starved for LOSE_MAX consecutive decisions.
  always_comb begin
    any_req  = m0_req | m1_req;
    grant_m1 = m1_req & (~m0_req | (lose_cnt_q == LOSE_MAX));
  end

  // Address decode and access legality on the latched request.
  always_comb begin
    hit_dm    = (addr_q <= DM_END);
    hit_t1    = ~hit_dm & (addr_q >= T1_LO) & (addr_q <= T1_HI);
    hit_t2    = ~hit_dm & (addr_q >= T2_LO) & (addr_q <= T2_HI);
    hit_timer = hit_t1 | hit_t2;
    is_write  = (byteen_q != 4'b0000);
    acc_err   = 1'b0;
    if (!(hit_dm | hit_timer)) begin
      acc_err = 1'b1;
    end else if (hit_timer) begin
      // Timers accept only whole-word, word-aligned accesses; offsets 8..B
      // inside each window (addr[3] set) hold the read-only count word.
      if ((byteen_q != 4'b0000) && (byteen_q != 4'b1111)) acc_err = 1'b1;
      if (addr_q[1:0] != 2'b00)                           acc_err = 1'b1;
      if (is_write && addr_q[3])                          acc_err = 1'b1;
    end
  end

  // Read data from whichever device the latched address selects.
  always_comb begin
    dev_rdata_mux = 32'h0;
    if (hit_dm)      dev_rdata_mux = dm_rdata;
    else if (hit_t1) dev_rdata_mux = t1_rdata;
    else if (hit_t2) dev_rdata_mux = t2_rdata;
  end

  // Next state: arbitration and latching in IDLE, data capture at end of ACC.
  always_comb begin
    state_d    = state_q;
    lose_cnt_d = lose_cnt_q;
    win_d      = win_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byteen_d   = byteen_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        // Count only decisions master 1 actually lost; any other IDLE
        // decision (master 1 wins or is not asking) restarts the count.
        if (m1_req && !grant_m1) begin
          lose_cnt_d = (lose_cnt_q == 2'd3) ? 2'd3 : lose_cnt_q + 2'd1;
        end else begin
          lose_cnt_d = 2'd0;
        end
        if (any_req) begin
          state_d  = ACC;
          win_d    = grant_m1;
          addr_d   = grant_m1 ? m1_addr   : m0_addr;
          wdata_d  = grant_m1 ? m1_wdata  : m0_wdata;
          byteen_d = grant_m1 ? m1_byteen : m0_byteen;
        end
      end
      ACC: begin
        state_d = RSP;
        err_d   = acc_err;
        // Writes and rejected accesses return zero.
        rdata_d = (acc_err || is_write) ? 32'h0 : dev_rdata_mux;
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lose_cnt_q <= 2'd0;
      win_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      byteen_q   <= 4'b0000;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lose_cnt_q <= lose_cnt_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      byteen_q   <= byteen_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Device bus: driven only during ACC, and only for a legal access.
  always_comb begin
    dev_addr   = addr_q;
    dev_wdata  = wdata_q;
    dev_byteen = 4'b0000;
    dm_sel     = 1'b0;
    t1_sel     = 1'b0;
    t2_sel     = 1'b0;
    if (state_q == ACC && !acc_err) begin
      dev_byteen = byteen_q;
      dm_sel     = hit_dm;
      t1_sel     = hit_t1;
      t2_sel     = hit_t2;
    end
  end

  // Master responses: the winner sees ack/err/rdata for the single RSP cycle.
  always_comb begin
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = 32'h0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = 32'h0;
    if (state_q == RSP) begin
      if (win_q) begin
        m1_ack   = 1'b1;
        m1_err   = err_q;
        m1_rdata = rdata_q;
      end else begin
        m0_ack   = 1'b1;
        m0_err   = err_q;
        m0_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then
// randomized masters checked every cycle against a cycle-count reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam logic [31:0] DM_END   = 32'h0000_2FFF;
  localparam int          LOSE_MAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v   [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [3:0]  be_v    [2];
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dev_addr, dev_wdata;
  logic [3:0]  dev_byteen;
  logic        dm_sel, t1_sel, t2_sel;
  logic [31:0] dm_rdata, t1_rdata, t2_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  bus_arbiter #(.DM_END(DM_END), .LOSE_MAX(2'd3)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]), .m0_byteen(be_v[0]),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(req_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]), .m1_byteen(be_v[1]),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_byteen(dev_byteen),
    .dm_sel(dm_sel), .t1_sel(t1_sel), .t2_sel(t2_sel),
    .dm_rdata(dm_rdata), .t1_rdata(t1_rdata), .t2_rdata(t2_rdata)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Legality rules written straight from the address map.
  function automatic void judge(input logic [31:0] a, input logic [3:0] be,
                                output int dev, output bit err);
    bit wr;
    wr = (be != 4'b0000);
    if (a <= DM_END)                          dev = 0;
    else if (a >= 32'h7F00 && a <= 32'h7F0B)  dev = 1;
    else if (a >= 32'h7F10 && a <= 32'h7F1B)  dev = 2;
    else                                      dev = 3;
    err = (dev == 3);
    if (dev == 1 || dev == 2) begin
      if (be != 4'b0000 && be != 4'b1111) err = 1;
      if (a % 4 != 0) err = 1;
      if (wr && ((a >= 32'h7F08 && a <= 32'h7F0B) || (a >= 32'h7F18 && a <= 32'h7F1B))) err = 1;
    end
  endfunction

  // ---- Reference model: edge counter, one pending transaction at a time ----
  int          cyc = 0;          // rising edges since reset release
  bit          pend = 0;
  int          g = 0;            // edge at which the pending request was granted
  int          next_grant = 0;   // earliest edge for the next grant
  int          losses = 0;
  int          mwin = 0;
  int          mdev = 3;
  bit          merr = 0;
  logic [31:0] ma = 0, mwd = 0, mcap = 0;
  logic [3:0]  mbe = 0;

  task automatic model_step();
    if (reset) begin
      cyc = 0; pend = 0; next_grant = 0; losses = 0; mcap = 0;
      return;
    end
    cyc++;
    if (pend && cyc == g + 1) begin
      if (merr || mbe != 4'b0000) mcap = 32'h0;
      else if (mdev == 0)         mcap = dm_rdata;
      else if (mdev == 1)         mcap = t1_rdata;
      else                        mcap = t2_rdata;
    end
    if (pend && cyc == g + 2) pend = 0;
    if (!pend && cyc >= next_grant) begin
      if (req_v[0] || req_v[1]) begin
        mwin = (req_v[1] && (!req_v[0] || losses >= LOSE_MAX)) ? 1 : 0;
        if (req_v[1] && mwin == 0) losses = (losses < 3) ? losses + 1 : 3;
        else                       losses = 0;
        ma  = addr_v[mwin];
        mwd = wdata_v[mwin];
        mbe = be_v[mwin];
        judge(ma, mbe, mdev, merr);
        g = cyc;
        pend = 1;
        next_grant = cyc + 3;
      end else begin
        losses = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // ---- Per-cycle comparison against the model ----
  initial begin
    bit          in_acc, in_rsp, e0, e1;
    logic [2:0]  es;
    logic [3:0]  eb;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_sel",    32'({dm_sel, t1_sel, t2_sel}), 32'h0);
        check("rst_byteen", 32'(dev_byteen), 32'h0);
        check("rst_ackerr", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_m1_rdata", m1_rdata, 32'h0);
      end else begin
        in_acc = pend && (cyc == g);
        in_rsp = pend && (cyc == g + 1);
        es = 3'b000;
        eb = 4'b0000;
        if (in_acc && !merr) begin
          es = (mdev == 0) ? 3'b100 : (mdev == 1) ? 3'b010 : 3'b001;
          eb = mbe;
        end
        check("sel", 32'({dm_sel, t1_sel, t2_sel}), 32'(es));
        check("dev_byteen", 32'(dev_byteen), 32'(eb));
        if (es != 3'b000) begin
          check("dev_addr", dev_addr, ma);
          check("dev_wdata", dev_wdata, mwd);
        end
        e0 = in_rsp && (mwin == 0);
        e1 = in_rsp && (mwin == 1);
        check("m0_ack", 32'(m0_ack), 32'(e0));
        check("m1_ack", 32'(m1_ack), 32'(e1));
        check("m0_err", 32'(m0_err), 32'(e0 && merr));
        check("m1_err", 32'(m1_err), 32'(e1 && merr));
        check("m0_rdata", m0_rdata, e0 ? mcap : 32'h0);
        check("m1_rdata", m1_rdata, e1 ? mcap : 32'h0);
      end
    end
  end

  // One directed transaction from an idle bus with literal expectations.
  task automatic directed(input string nm, input int m, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [2:0] exp_sel, input logic [3:0] exp_be,
                          input logic exp_err, input logic [31:0] exp_rd);
    logic [1:0] exp_acks;
    @(posedge clk); #2;
    addr_v[m] = a; wdata_v[m] = wd; be_v[m] = be; req_v[m] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_sel"}, 32'({dm_sel, t1_sel, t2_sel}), 32'(exp_sel));
    check({nm, "_byteen"}, 32'(dev_byteen), 32'(exp_be));
    if (exp_sel != 3'b000) check({nm, "_addr"}, dev_addr, a);
    check({nm, "_noack"}, 32'({m0_ack, m1_ack}), 32'h0);
    @(negedge clk);
    exp_acks = (m == 0) ? 2'b10 : 2'b01;
    check({nm, "_acks"}, 32'({m0_ack, m1_ack}), 32'(exp_acks));
    check({nm, "_err"}, 32'((m == 0) ? m0_err : m1_err), 32'(exp_err));
    check({nm, "_rdata"}, (m == 0) ? m0_rdata : m1_rdata, exp_rd);
    check({nm, "_other_rdata"}, (m == 0) ? m1_rdata : m0_rdata, 32'h0);
    req_v[m] = 1'b0;
    $display("directed %s done", nm);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1:    return 32'($urandom_range(0, 32'h2FFF));
      2:       return 32'h0000_2FFC + 32'($urandom_range(0, 7));
      3, 4:    return 32'h0000_7F00 + 32'($urandom_range(0, 15));
      5:       return 32'h0000_7F10 + 32'($urandom_range(0, 15));
      6:       return 32'h0000_7EFC + 32'($urandom_range(0, 7));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [3:0] rand_be();
    case ($urandom_range(0, 3))
      0:       return 4'b0000;
      1:       return 4'b1111;
      2:       return 4'b0000;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int got [8];
    int exp_seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int n_got;
    int budget;
    int hold [2];
    logic ack_m;

    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 1'b0; addr_v[m] = 32'h0; wdata_v[m] = 32'h0; be_v[m] = 4'b0;
      hold[m] = 0;
    end
    dm_rdata = 32'hDEAD_BEEF; t1_rdata = 32'h1111_1111; t2_rdata = 32'h0000_0005;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Directed scenarios.
    directed("dm_read",    0, 32'h0000_0010, 32'h0, 4'b0000, 3'b100, 4'b0000, 1'b0, 32'hDEAD_BEEF);
    directed("t1_ro_wr",   0, 32'h0000_7F08, 32'h1234_5678, 4'b1111, 3'b000, 4'b0000, 1'b1, 32'h0);
    directed("miss_wr",    1, 32'h0000_3000, 32'h0000_00AA, 4'b0001, 3'b000, 4'b0000, 1'b1, 32'h0);
    directed("t2_read",    1, 32'h0000_7F14, 32'h0, 4'b0000, 3'b001, 4'b0000, 1'b0, 32'h0000_0005);
    directed("dm_part_wr", 0, 32'h0000_0100, 32'hCAFE_F00D, 4'b0011, 3'b100, 4'b0011, 1'b0, 32'h0);
    directed("t1_misalgn", 0, 32'h0000_7F02, 32'h0, 4'b0000, 3'b000, 4'b0000, 1'b1, 32'h0);
    directed("t1_wr",      1, 32'h0000_7F04, 32'h0000_0064, 4'b1111, 3'b010, 4'b1111, 1'b0, 32'h0);
    directed("dm_top_rd",  0, 32'h0000_2FFC, 32'h0, 4'b0000, 3'b100, 4'b0000, 1'b0, 32'hDEAD_BEEF);

    // Both masters held high: grant order m0,m0,m0,m1 repeating.
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    addr_v[0] = 32'h40; be_v[0] = 4'b0; addr_v[1] = 32'h80; be_v[1] = 4'b0;
    req_v[0] = 1'b1; req_v[1] = 1'b1;
    for (int k = 0; k < 8; k++) got[k] = -1;
    n_got = 0;
    budget = 0;
    while (n_got < 8 && budget < 60) begin
      @(negedge clk);
      budget++;
      if (m0_ack)      begin got[n_got] = 0; n_got++; end
      else if (m1_ack) begin got[n_got] = 1; n_got++; end
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    check("fair_count", 32'(n_got), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("fair_grant%0d", k), 32'(got[k]), 32'(exp_seq[k]));
      $display("fair grant %0d -> m%0d", k, got[k]);
    end

    // Reset during ACC of an m0 write: abandoned, then re-granted.
    @(posedge clk); #2;
    addr_v[0] = 32'h20; wdata_v[0] = 32'h0000_CAFE; be_v[0] = 4'b1111; req_v[0] = 1'b1;
    @(posedge clk); #2;
    check("rst_acc_sel", 32'(dm_sel), 32'h1);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    check("rst_acc_sel_drop", 32'(dm_sel), 32'h0);
    check("rst_acc_noack", 32'(m0_ack), 32'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_regrant_sel", 32'(dm_sel), 32'h1);
    check("rst_regrant_be", 32'(dev_byteen), 32'hF);
    @(negedge clk);
    check("rst_regrant_ack", 32'({m0_ack, m0_err}), 32'b10);
    req_v[0] = 1'b0;
    $display("reset-in-ACC scenario done");

    // Randomized masters.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      dm_rdata = $urandom; t1_rdata = $urandom; t2_rdata = $urandom;
      reset = ($urandom_range(0, 499) == 0);
      for (int m = 0; m < 2; m++) begin
        ack_m = (m == 0) ? m0_ack : m1_ack;
        if (req_v[m] && ack_m) begin
          $display("txn m%0d addr %h be %h done", m, addr_v[m], be_v[m]);
          req_v[m] = 1'b0;
          hold[m] = 0;
        end
        if (reset) hold[m] = 0;
        if (req_v[m]) begin
          hold[m]++;
          if (hold[m] > 30) begin
            n_assert++;
            n_fail++;
            $display("FAIL req_timeout m%0d: held %0d cycles, required ack within 30", m, hold[m]);
            req_v[m] = 1'b0;
            hold[m] = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          addr_v[m]  = rand_addr();
          wdata_v[m] = $urandom;
          be_v[m]    = rand_be();
          req_v[m]   = 1'b1;
          hold[m]    = 0;
        end
      end
    end
    @(posedge clk); #2;
    reset = 1'b0; req_v[0] = 1'b0; req_v[1] = 1'b0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
